instr_fetch_queue: RTL and testbench

Instruction prefetch stage between the instruction memory and the IF/ID pipeline register. It owns the fetch program counter, reads one 32-bit instruction per cycle from the combinational instruction memory, and buffers up to DEPTH {pc, instruction} pairs. Decode drains the buffer with a valid/ready handshake, so decode stalls no longer freeze fetch. A taken-branch redirect from EX/MEM flushes the buffer and restarts fetch at the target.

---
 rtl/instr_fetch_queue.sv | 106 ++++++++++
 tb/tb_instr_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction prefetch buffer between instruction memory
// and the IF/ID register. Owns the fetch PC, enqueues one {pc, instr} pair per
// cycle while space remains, and presents the oldest entry to decode through
// a valid/ready handshake. A redirect flushes the buffer and restarts fetch.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   imem_addr    fetch PC driven to the instruction memory
//   imem_data    instruction at imem_addr (combinational memory)
//   redirect     taken branch from EX/MEM: flush and refetch
//   redirect_pc  branch target, sampled while redirect=1
//   deq_ready    decode accepts the head entry this cycle
//   out_valid    head entry present
//   out_instr    head instruction, NOP when empty
//   out_pc       head PC, zero when empty
//   count        occupied entries, 0..DEPTH
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [63:0]                imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect,
  input  logic [63:0]                redirect_pc,
  input  logic                       deq_ready,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [63:0]                out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [63:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic enq_c;
  logic deq_c;

  // Full blocks enqueue even when a dequeue happens the same cycle.
  assign enq_c = (count_q < CNT_W'(DEPTH)) & ~redirect;
  assign deq_c = (count_q != '0) & deq_ready & ~redirect;

  // Next-state: redirect flushes everything and reloads the fetch PC.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (enq_c) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (deq_c) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq_c) - CNT_W'(deq_c);
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; never reset, only read through head while count != 0.
  always_ff @(posedge clock) begin
    if (enq_c) begin
      pc_mem[tail_q]    <= fetch_pc_q;
      instr_mem[tail_q] <= imem_data;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[head_q] : NOP;
  assign out_pc    = out_valid ? pc_mem[head_q] : 64'h0;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model compared every
// cycle, plus directed literal expectations along the test plan.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        deq_ready = 1'b1;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_err    = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return {16'hAABB, a[15:0]};
  endfunction

  assign imem_data = imem_word(imem_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of {pc, instr} and a fetch PC.
  logic [63:0] m_pc_q[$];
  logic [31:0] m_ins_q[$];
  logic [63:0] m_fetch = RESET_PC;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc_q.delete();
      m_ins_q.delete();
      m_fetch = RESET_PC;
    end else if (redirect) begin
      m_pc_q.delete();
      m_ins_q.delete();
      m_fetch = redirect_pc;
    end else begin
      automatic bit do_deq = (m_pc_q.size() > 0) && deq_ready;
      automatic bit do_enq = (m_pc_q.size() < DEPTH);
      if (do_deq) begin
        void'(m_pc_q.pop_front());
        void'(m_ins_q.pop_front());
      end
      if (do_enq) begin
        m_pc_q.push_back(m_fetch);
        m_ins_q.push_back(imem_word(m_fetch));
        m_fetch = m_fetch + 64'd4;
      end
    end
  end

  // Dequeued PCs as seen at the DUT output, for the wrap-around check.
  logic [63:0] dq_log[$];
  bit          log_en = 1'b0;

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    automatic bit    e_valid = (m_pc_q.size() > 0);
    automatic logic [63:0] e_pc  = e_valid ? m_pc_q[0] : 64'h0;
    automatic logic [31:0] e_ins = e_valid ? m_ins_q[0] : NOP;
    chk("model_imem_addr", imem_addr, m_fetch);
    chk("model_out_valid", 64'(out_valid), 64'(e_valid));
    chk("model_out_pc", out_pc, e_pc);
    chk("model_out_instr", 64'(out_instr), 64'(e_ins));
    chk("model_count", 64'(count), 64'(m_pc_q.size()));
    if (log_en && out_valid && deq_ready && !redirect && reset)
      dq_log.push_back(out_pc);
  end

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    deq_ready = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'(NOP));
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_imem_addr", imem_addr, 64'h100);
    reset = 1'b1;

    // Streaming with deq_ready=1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_out_pc", out_pc, 64'h100 + 64'(4 * i));
      chk("stream_out_instr", 64'(out_instr), 64'(32'hAABB0100 + 32'(4 * i)));
      chk("stream_count", 64'(count), 64'h1);
    end

    // Fill then drain
    deq_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fill_count", 64'(count), (i < 4) ? 64'(i + 1) : 64'h4);
      chk("fill_out_pc", out_pc, 64'h100);
      if (i >= 3) chk("fill_imem_addr", imem_addr, 64'h110);
    end
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_out_pc", out_pc, 64'h104 + 64'(4 * i));
    end

    // Redirect with 3 entries
    deq_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    chk("pre_redir_count", 64'(count), 64'h3);
    redirect = 1'b1; redirect_pc = 64'h400;
    tick();
    redirect = 1'b0;
    chk("redir_out_valid", 64'(out_valid), 64'h0);
    chk("redir_count", 64'(count), 64'h0);
    chk("redir_imem_addr", imem_addr, 64'h400);
    deq_ready = 1'b1;
    tick();
    chk("post_redir_out_pc", out_pc, 64'h400);
    chk("post_redir_valid", 64'(out_valid), 64'h1);

    // Redirect while full, twice in a row
    deq_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk("full_count", 64'(count), 64'h4);
    redirect = 1'b1; redirect_pc = 64'h200;
    tick();
    chk("dbl_redir1_count", 64'(count), 64'h0);
    redirect_pc = 64'h300;
    tick();
    redirect = 1'b0;
    chk("dbl_redir2_count", 64'(count), 64'h0);
    chk("dbl_redir2_addr", imem_addr, 64'h300);
    tick();
    chk("dbl_redir_out_pc", out_pc, 64'h300);
    chk("dbl_redir_count", 64'(count), 64'h1);

    // Wrap-around with alternating deq_ready
    dq_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      deq_ready = (i % 2 == 0);
      tick();
    end
    #3;
    log_en = 1'b0;
    deq_ready = 1'b0;
    chk("wrap_deq_count", 64'(dq_log.size()), 64'd10);
    if (dq_log.size() > 0) chk("wrap_first_pc", dq_log[0], 64'h300);
    for (int i = 1; i < dq_log.size(); i++)
      chk("wrap_pc_step", dq_log[i] - dq_log[i-1], 64'h4);

    // Asynchronous reset pulse between edges
    do_reset();
    tick(); tick(); tick();
    chk("pre_async_count", 64'(count), 64'h3);
    reset = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'h0);
    chk("async_count", 64'(count), 64'h0);
    chk("async_out_pc", out_pc, 64'h0);
    #3;
    reset = 1'b1;
    tick();
    chk("async_first_pc", out_pc, 64'h100);
    chk("async_first_valid", 64'(out_valid), 64'h1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
